// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
//  - im constants: start address, size in words, enable level
//  - fetch FSM state encoding
//  - fetch queue entry layout (instr, pc, fault)
//  - address legality helper used by the fault check
package fetch_ctrl_pkg;

  localparam logic [31:0] IM_START_ADDRESS = 32'h0000_3000;
  localparam int unsigned IM_SIZE          = 1024;
  localparam logic        IM_ENABLE        = 1'b1;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_RUN  = 2'd1,
    FC_HALT = 2'd2
  } fc_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fq_entry_t;

  // Word-aligned and inside [base, base + 4*words). The upper bound is
  // formed in 33 bits so a range ending at 2^32 cannot wrap.
  function automatic logic fc_addr_legal(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(words) << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between fetch_ctrl and its neighbours.
//  redirect_valid/redirect_target : PC change request from execute
//  im_addr/im_enable/im_result    : combinational instruction memory port
//  out_valid/out_ready/out_*      : fetched-instruction handshake to decode
//  master : the fetch controller side; slave : the environment side.
interface fetch_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] im_addr;
  logic        im_enable;
  logic [31:0] im_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  modport master (
    input  redirect_valid, redirect_target, im_result, out_ready,
    output im_addr, im_enable, out_valid, out_instr, out_pc, out_fault
  );

  modport slave (
    output redirect_valid, redirect_target, im_result, out_ready,
    input  im_addr, im_enable, out_valid, out_instr, out_pc, out_fault
  );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched entries (instr, pc, fault).
//  clk, reset      : clock, asynchronous active-high reset
//  flush           : empties the queue; overrides enq
//  enq, enq_data   : push request and entry; accepted when not full or when
//                    a dequeue happens in the same cycle
//  deq             : pop the head (ignored when empty)
//  count           : number of stored entries
//  head_valid/data : head entry; data reads as zero when empty
// QDEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter  int unsigned QDEPTH = 2,
  localparam int unsigned PW     = $clog2(QDEPTH),
  localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq,
  input  fq_entry_t     enq_data,
  input  logic          deq,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output fq_entry_t     head_data
);

  fq_entry_t      mem [QDEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_enq;
  logic           do_deq;

  always_comb begin
    do_deq = deq && (count != '0);
    do_enq = enq && !flush && ((count < CW'(QDEPTH)) || do_deq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_enq && !do_deq) begin
        count <= count + CW'(1);
      end else if (!do_enq && do_deq) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller between the PC logic and decode.
//  clk, reset : clock, asynchronous active-high reset
//  bus        : fetch_ctrl_if master modport (redirect in, im port,
//               decode handshake out)
// Owns the PC, drives the combinational instruction memory, flags
// misaligned/out-of-range fetches as fault entries, and buffers results
// in a fetch_queue. Redirects flush the queue and restart fetching.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] START_ADDR = IM_START_ADDRESS,
  parameter int unsigned IM_WORDS   = IM_SIZE,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fc_state_e     state;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic          head_valid;
  fq_entry_t     head_data;
  fq_entry_t     enq_data;
  logic          pc_legal;
  logic          can_enq;
  logic          enq;

  always_comb begin
    pc_legal = fc_addr_legal(pc, START_ADDR, IM_WORDS);
    // A same-cycle dequeue frees a slot, so a full queue still accepts.
    can_enq  = (count < CW'(QDEPTH)) || (head_valid && bus.out_ready);
    enq      = (state == FC_RUN) && can_enq && !bus.redirect_valid;
    if (pc_legal) begin
      enq_data = '{instr: bus.im_result, pc: pc, fault: 1'b0};
    end else begin
      enq_data = '{instr: '0, pc: pc, fault: 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= START_ADDR;
      state <= FC_IDLE;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_target;
      state <= FC_RUN;
    end else begin
      case (state)
        FC_IDLE: state <= FC_RUN;
        FC_RUN: begin
          if (can_enq) begin
            if (pc_legal) begin
              pc <= pc + 32'd4;
            end else begin
              state <= FC_HALT;
            end
          end
        end
        FC_HALT: state <= FC_HALT;
        default: state <= FC_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect_valid),
    .enq        (enq),
    .enq_data   (enq_data),
    .deq        (bus.out_ready),
    .count      (count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign bus.im_addr   = pc;
  assign bus.im_enable = ((state == FC_RUN) && can_enq && pc_legal) ? IM_ENABLE : ~IM_ENABLE;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head_data.instr;
  assign bus.out_pc    = head_data.pc;
  assign bus.out_fault = head_data.fault;

endmodule
